// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: a sample FIFO drained at a fixed rate into a held DAC word.
// Define AUDIO_FIFO_UNDERRUN_MUTE_EN to load mid-scale (0) on an underrun tick instead of holding.
module audio_sample_fifo #(
    parameter int SAMPLE_BITS = 12,
    parameter int DEPTH_LOG2  = 4,
    parameter int CLK_DIV     = 363
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic signed [SAMPLE_BITS-1:0] wr_data,
    output logic signed [SAMPLE_BITS-1:0] sample_out,
    output logic                          sample_tick,
    output logic [DEPTH_LOG2:0]           level,
    output logic                          underrun,
    input  logic                          underrun_clr
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic                          running;
    logic [CNT_W-1:0]              cnt;
    logic [DEPTH_LOG2-1:0]         wr_ptr;
    logic [DEPTH_LOG2-1:0]         rd_ptr;
    logic signed [SAMPLE_BITS-1:0] mem [DEPTH];
    logic                          push;
    logic                          pop;
    logic                          underrun_set;

    // running holds the divider and wr_ready off until the first edge after reset release,
    // so the first tick lands CLK_DIV cycles after deassertion.
    assign sample_tick  = running && (cnt == CNT_LAST);
    assign wr_ready     = running && (level != LEVEL_FULL);
    assign push         = wr_valid && wr_ready;
    assign pop          = sample_tick && (level != '0);
    assign underrun_set = sample_tick && (level == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            running <= 1'b0;
            cnt     <= '0;
        end else begin
            running <= 1'b1;
            if (running) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_out <= '0;
        end else if (pop) begin
            sample_out <= mem[rd_ptr];
`ifdef AUDIO_FIFO_UNDERRUN_MUTE_EN
        end else if (underrun_set) begin
            sample_out <= '0;
`endif
        end
    end

    // A new underrun event takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underrun <= 1'b0;
        end else if (underrun_set) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 The block SHALL have parameter SAMPLE_BITS, default 12: width of the signed audio sample.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 entries.
REQ-003 The block SHALL have parameter CLK_DIV, default 363, legal range 2..65535: clk cycles per output sample.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port wr_valid, input, 1 bit: the producer offers wr_data.
REQ-007 The block SHALL have port wr_ready, output, 1 bit: the FIFO can accept a sample.
REQ-008 The block SHALL have port wr_data, input, SAMPLE_BITS bits: signed two's-complement sample.
REQ-009 The block SHALL have port sample_out, output, SAMPLE_BITS bits: signed held sample, feeding the PDM DAC din.
REQ-010 The block SHALL have port sample_tick, output, 1 bit: one-cycle pulse at each sample period.
REQ-011 The block SHALL have port level, output, DEPTH_LOG2+1 bits: current FIFO occupancy.
REQ-012 The block SHALL have port underrun, output, 1 bit: sticky flag, set when a tick finds the FIFO empty.
REQ-013 The block SHALL have port underrun_clr, input, 1 bit: clears underrun.

Function
REQ-014 The divider counter SHALL count 0..CLK_DIV-1 and wrap to 0.
REQ-015 sample_tick SHALL be high for exactly the one cycle in which the counter equals CLK_DIV-1, giving a period of CLK_DIV cycles.
REQ-016 A push SHALL occur on an edge where wr_valid and wr_ready are both high; wr_data is written at the tail.
REQ-017 wr_ready SHALL equal (level != 2**DEPTH_LOG2), decoded from registered state only, so it does not depend on wr_valid.
REQ-018 When full, wr_ready SHALL remain low even in a cycle where a pop occurs.
REQ-019 On an edge where sample_tick is high and level > 0, the head entry SHALL be popped into sample_out; sample_out shows the new value from the following cycle.
REQ-020 sample_out SHALL hold its value between pops.
REQ-021 On a simultaneous push and pop, both SHALL take effect and level SHALL remain unchanged.
REQ-022 A push into an empty FIFO SHALL NOT appear on sample_out in the same cycle; there is no bypass path.
REQ-023 Read and write pointers SHALL be DEPTH_LOG2 bits, wrap modulo the depth, and use level to distinguish full from empty.
REQ-024 On an edge where sample_tick is high and level == 0, underrun SHALL be set and the FIFO state SHALL be left unchanged.
REQ-025 An underrun_clr asserted in the same cycle as a new underrun event SHALL leave underrun set, because set wins.
REQ-026 The FIFO SHALL never overflow or underflow its pointers; level SHALL stay within 0..2**DEPTH_LOG2.

Reset
REQ-027 While resetn is low, the block SHALL hold: sample_out=0, level=0, wr_ready=0, underrun=0, sample_tick=0, divider counter=0, pointers=0.
REQ-028 wr_ready SHALL rise in the first cycle after resetn deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all queued samples immediately; deassertion is synchronised externally.
REQ-030 The first sample_tick after reset SHALL occur CLK_DIV cycles after resetn deasserts.

Configuration
REQ-031 Macro AUDIO_FIFO_UNDERRUN_MUTE_EN SHALL select underrun behaviour.
REQ-032 With AUDIO_FIFO_UNDERRUN_MUTE_EN defined, an underrun tick SHALL load sample_out with 0, which is mid-scale at the DAC.
REQ-033 Without AUDIO_FIFO_UNDERRUN_MUTE_EN, sample_out SHALL hold its last value on an underrun tick.
REQ-034 Setting of the underrun flag SHALL be identical in both builds.

Verification
REQ-035 CLK_DIV=4, no writes after reset -> sample_tick high at cycles 4, 8, 12 after deassertion; underrun=1 after the first tick; sample_out=0.
REQ-036 Push 0x7FF, 0x800, 0x123 back to back -> level 1,2,3; successive ticks give sample_out 0x7FF, 0x800, 0x123; level returns to 0.
REQ-037 With wr_valid held high, fill 16 entries -> wr_ready=0 at level 16; hold wr_valid through a tick -> level 15, then the next cycle wr_ready=1 and the push completes, level returns to 16.
REQ-038 Push coincident with a tick at level 5 -> level stays 5; the popped value is the oldest entry.
REQ-039 Underrun with last sample 0x3A0 -> sample_out stays 0x3A0 without the macro and becomes 0 with it; underrun_clr pulsed on the same edge as a second underrun -> underrun stays 1.
REQ-040 Assert resetn low at level 7 mid-period -> all outputs at reset values immediately; after release the first tick occurs CLK_DIV cycles later.
